// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Two-port arbiter in front of a single-ported 64-bit memory. One access is
//   issued per cycle; grant and memory command are combinational in the issue
//   cycle and read data returns one cycle later through the response FSM.
//   Data port has priority over fetch.
//
// Build option:
//   MEM_ARB_STARVE_EN  defined   -> starvation counter forces a fetch grant
//                                   after STARVE_LIMIT consecutive data wins
//                      undefined -> strict data-over-fetch priority
//
// Parameters:
//   ADDR_WIDTH    doubleword address width (default 10)
//   STARVE_LIMIT  data wins tolerated while fetch waits, 1..7 (default 4)
//
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   if_req/if_addr                fetch read request
//   if_gnt/if_rvalid/if_rdata     fetch grant and read response
//   d_req/d_we/d_addr/d_wdata/d_wstrb  data request
//   d_gnt/d_rvalid/d_rdata        data grant and load response
//   mem_addr/mem_re/mem_we/mem_wstrb/mem_wdata  memory command
//   mem_rdata                     memory read data, one cycle after mem_re
module mem_arbiter #(
    parameter int ADDR_WIDTH   = 10,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_gnt,
    output logic                  if_rvalid,
    output logic [63:0]           if_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [63:0]           d_wdata,
    input  logic [7:0]            d_wstrb,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [63:0]           d_rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_re,
    output logic                  mem_we,
    output logic [7:0]            mem_wstrb,
    output logic [63:0]           mem_wdata,
    input  logic [63:0]           mem_rdata
);

    // State names the owner of the response arriving next cycle.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RD_IF = 2'd1,
        RD_D  = 2'd2,
        WR    = 2'd3
    } state_t;

    localparam logic [2:0] LP_LIMIT = 3'(STARVE_LIMIT);

    state_t r_state;
    state_t w_state_nxt;
    logic   w_starve;
    logic   w_if_win;
    logic   w_d_win;

`ifdef MEM_ARB_STARVE_EN
    logic [2:0] r_starve_cnt;

    assign w_starve = if_req && (r_starve_cnt == LP_LIMIT);

    // Counts data wins while fetch is waiting; saturates at the limit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_starve_cnt <= '0;
        end else if (if_gnt || !if_req) begin
            r_starve_cnt <= '0;
        end else if (d_gnt && (r_starve_cnt != LP_LIMIT)) begin
            r_starve_cnt <= r_starve_cnt + 3'd1;
        end
    end
`else
    // Constant-false for the legal 1..7 limit range: strict data priority.
    assign w_starve = if_req && (LP_LIMIT == 3'd0);
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Grant, memory command and next state. Grants are gated by rst so the
    // memory sees no command while reset is held.
    always_comb begin
        w_d_win     = rst && d_req && !w_starve;
        w_if_win    = rst && if_req && !w_d_win;
        if_gnt      = w_if_win;
        d_gnt       = w_d_win;
        mem_addr    = '0;
        mem_re      = 1'b0;
        mem_we      = 1'b0;
        mem_wstrb   = '0;
        mem_wdata   = '0;
        w_state_nxt = IDLE;
        if (w_d_win) begin
            mem_addr = d_addr;
            if (d_we) begin
                mem_we      = 1'b1;
                mem_wstrb   = d_wstrb;
                mem_wdata   = d_wdata;
                w_state_nxt = WR;
            end else begin
                mem_re      = 1'b1;
                w_state_nxt = RD_D;
            end
        end else if (w_if_win) begin
            mem_addr    = if_addr;
            mem_re      = 1'b1;
            w_state_nxt = RD_IF;
        end
    end

    // Response steering from the registered owner.
    always_comb begin
        if_rvalid = (r_state == RD_IF);
        d_rvalid  = (r_state == RD_D);
        if_rdata  = if_rvalid ? mem_rdata : '0;
        d_rdata   = d_rvalid  ? mem_rdata : '0;
    end

endmodule
